noc_pe_interface: RTL and testbench

Leaf-side network interface connecting one processing element (PE) to a port of the synchronous butterfly-tree NoC. Builds NoC flits by packing a destination address into the flit MSBs. Buffers injection and ejection traffic in small FIFOs and speaks the NoC valid/ready handshake toward the leaf switch. On the receive side it strips the address, checks the flit is addressed to this PE, and delivers the payload to the PE.

---
 rtl/noc_pkg.sv | 29 ++
 rtl/noc_flit_fifo.sv | 62 ++++++
 rtl/noc_pe_interface.sv | 125 ++++++++++++
 tb/tb_noc_pe_interface.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: field positions, widths and pack/unpack helpers.
package noc_pkg;

  localparam int NOC_DATA_WIDTH    = 34;
  localparam int NOC_ADDR_WIDTH    = 2;
  localparam int NOC_ADDR_MSB      = NOC_DATA_WIDTH - 1;
  localparam int NOC_ADDR_LSB      = NOC_DATA_WIDTH - NOC_ADDR_WIDTH;
  localparam int NOC_PAYLOAD_WIDTH = NOC_DATA_WIDTH - NOC_ADDR_WIDTH;

  typedef logic [NOC_DATA_WIDTH-1:0]    flit_t;
  typedef logic [NOC_ADDR_WIDTH-1:0]    addr_t;
  typedef logic [NOC_PAYLOAD_WIDTH-1:0] payload_t;

  // Destination leaf address carried in the flit MSBs.
  function automatic addr_t flit_dest(input flit_t flit);
    return flit[NOC_ADDR_MSB:NOC_ADDR_LSB];
  endfunction

  // Payload with the address field stripped.
  function automatic payload_t flit_payload(input flit_t flit);
    return flit[NOC_PAYLOAD_WIDTH-1:0];
  endfunction

  // Packs a destination into the MSBs above the payload.
  function automatic flit_t make_flit(input addr_t dest, input payload_t payload);
    return {dest, payload};
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Small synchronous FIFO with extra-MSB pointers. The head word is presented
// combinationally and reads as zero when empty. push is ignored when full and
// pop when empty; no same-cycle pass-through.
module noc_flit_fifo
#(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [Width-1:0] o_head
);

  localparam int AW = $clog2(Depth);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_head  = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // State registers; reset discards all contents.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/noc_pe_interface.sv
// PE-to-NoC leaf interface: TX FIFO packs {dest, payload} toward the switch,
// RX FIFO delivers payloads addressed to MyAddr and drops misrouted flits.
// All handshakes: a transfer happens on a rising edge when valid && ready;
// valid never depends on ready, and data is held while valid && !ready.
// Optional feature macro: NOC_IFACE_LOOPBACK_EN routes self-addressed TX
// flits straight into the RX FIFO (NoC ingress wins RX contention).
module noc_pe_interface
  import noc_pkg::*;
#(
  parameter int DataWidth = NOC_DATA_WIDTH,
  parameter int AddrWidth = NOC_ADDR_WIDTH,
  parameter int MyAddr    = 0,
  parameter int FifoDepth = 4
) (
  input  logic                           i_sclk,
  input  logic                           i_reset,
  input  logic [DataWidth-AddrWidth-1:0] i_pe_data,
  input  logic [AddrWidth-1:0]           i_pe_dest,
  input  logic                           i_pe_data_valid,
  output logic                           o_pe_data_ready,
  output logic [DataWidth-1:0]           o_noc_data,
  output logic                           o_noc_data_valid,
  input  logic                           i_noc_data_ready,
  input  logic [DataWidth-1:0]           i_noc_data,
  input  logic                           i_noc_data_valid,
  output logic                           o_noc_data_ready,
  output logic [DataWidth-AddrWidth-1:0] o_pe_data,
  output logic                           o_pe_data_valid,
  input  logic                           i_pe_data_ready,
  output logic                           o_misroute,
  output logic [7:0]                     o_misroute_count
);

  localparam int                   PayloadWidth = DataWidth - AddrWidth;
  localparam logic [AddrWidth-1:0] MyAddrBits   = AddrWidth'(MyAddr);

  logic                    ready_en_q, ready_en_d;
  logic                    misroute_q, misroute_d;
  logic [7:0]              misroute_count_q, misroute_count_d;

  logic                    tx_push, tx_pop, tx_full, tx_empty;
  logic [DataWidth-1:0]    tx_head;
  logic                    rx_push, rx_full, rx_empty;
  logic [PayloadWidth-1:0] rx_push_data, rx_head;

  logic                    noc_accept, noc_for_me, rx_push_noc;
  logic                    tx_head_self, noc_out_valid, lb_go;

  // ready_en_q keeps both readies low during reset and for the release cycle.
  assign o_pe_data_ready  = ready_en_q && !tx_full;
  assign o_noc_data_ready = ready_en_q && !rx_full;

  assign tx_push      = i_pe_data_valid && o_pe_data_ready;
  assign noc_accept   = i_noc_data_valid && o_noc_data_ready;
  assign noc_for_me   = (flit_dest(i_noc_data) == MyAddrBits);
  assign rx_push_noc  = noc_accept && noc_for_me;
  assign tx_head_self = (flit_dest(tx_head) == MyAddrBits);

`ifdef NOC_IFACE_LOOPBACK_EN
  // Self-addressed head bypasses the NoC; yields the RX slot to NoC ingress.
  assign noc_out_valid = !tx_empty && !tx_head_self;
  assign lb_go         = !tx_empty && tx_head_self && !rx_push_noc && !rx_full;
`else
  assign noc_out_valid = !tx_empty;
  assign lb_go         = 1'b0;
`endif

  assign tx_pop           = (noc_out_valid && i_noc_data_ready) || lb_go;
  assign o_noc_data_valid = noc_out_valid;
  assign o_noc_data       = noc_out_valid ? tx_head : '0;

  assign rx_push      = rx_push_noc || lb_go;
  assign rx_push_data = rx_push_noc ? flit_payload(i_noc_data) : flit_payload(tx_head);

  assign o_pe_data_valid  = !rx_empty;
  assign o_pe_data        = rx_head;
  assign o_misroute       = misroute_q;
  assign o_misroute_count = misroute_count_q;

  noc_flit_fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_tx_fifo (
    .i_clk       (i_sclk),
    .i_rst       (i_reset),
    .i_push      (tx_push),
    .i_push_data (make_flit(i_pe_dest, i_pe_data)),
    .i_pop       (tx_pop),
    .o_full      (tx_full),
    .o_empty     (tx_empty),
    .o_head      (tx_head)
  );

  noc_flit_fifo #(.Width(PayloadWidth), .Depth(FifoDepth)) u_rx_fifo (
    .i_clk       (i_sclk),
    .i_rst       (i_reset),
    .i_push      (rx_push),
    .i_push_data (rx_push_data),
    .i_pop       (i_pe_data_ready),
    .o_full      (rx_full),
    .o_empty     (rx_empty),
    .o_head      (rx_head)
  );

  // Misroute pulse and saturating counter for dropped flits.
  always_comb begin
    ready_en_d       = 1'b1;
    misroute_d       = noc_accept && !noc_for_me;
    misroute_count_d = misroute_count_q;
    if (misroute_d && (misroute_count_q != 8'hFF)) begin
      misroute_count_d = misroute_count_q + 8'd1;
    end
  end

  // Control registers.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      ready_en_q       <= 1'b0;
      misroute_q       <= 1'b0;
      misroute_count_q <= '0;
    end else begin
      ready_en_q       <= ready_en_d;
      misroute_q       <= misroute_d;
      misroute_count_q <= misroute_count_d;
    end
  end

endmodule

// File: tb/tb_noc_pe_interface.sv
// Self-checking bench for noc_pe_interface: directed scenarios plus random
// traffic, every cycle compared against a queue-based reference model.
module tb_noc_pe_interface;

  localparam int             DW    = 34;
  localparam int             AW    = 2;
  localparam int             PW    = 32;
  localparam int             DEPTH = 4;
  localparam logic [AW-1:0]  MY    = 2'd0;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pe_data_in;
  logic [AW-1:0] pe_dest_in;
  logic          pe_valid_in;
  logic          pe_ready_out;
  logic [DW-1:0] noc_data_out;
  logic          noc_valid_out;
  logic          noc_ready_in;
  logic [DW-1:0] noc_data_in;
  logic          noc_valid_in;
  logic          noc_ready_out;
  logic [PW-1:0] pe_data_out;
  logic          pe_valid_out;
  logic          pe_ready_in;
  logic          misroute;
  logic [7:0]    misroute_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [DW-1:0] tx_q[$];
  logic [PW-1:0] rx_q[$];
  bit            ready_ok;
  int            mis_cnt;
  bit            mis_pend;
  bit            pe_acc;
  bit            noc_in_acc;

  int            sent;
  int            mis_seen;
  logic [AW-1:0] rnd_dest;

  noc_pe_interface dut (
    .i_sclk           (clk),
    .i_reset          (rst),
    .i_pe_data        (pe_data_in),
    .i_pe_dest        (pe_dest_in),
    .i_pe_data_valid  (pe_valid_in),
    .o_pe_data_ready  (pe_ready_out),
    .o_noc_data       (noc_data_out),
    .o_noc_data_valid (noc_valid_out),
    .i_noc_data_ready (noc_ready_in),
    .i_noc_data       (noc_data_in),
    .i_noc_data_valid (noc_valid_in),
    .o_noc_data_ready (noc_ready_out),
    .o_pe_data        (pe_data_out),
    .o_pe_data_valid  (pe_valid_out),
    .i_pe_data_ready  (pe_ready_in),
    .o_misroute       (misroute),
    .o_misroute_count (misroute_count)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: settle, compare all outputs to the model, clock, update.
  task automatic step();
    bit            exp_pe_ready, exp_noc_ready, exp_noc_valid, exp_pe_valid;
    bit            head_self, lb_mode, noc_in_me, noc_out_acc, lb, rx_pop;
    logic [DW-1:0] exp_noc_data;
    logic [PW-1:0] exp_pe_data;
    logic [DW-1:0] head;
    #1;
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      ready_ok = 0;
      mis_cnt  = 0;
      mis_pend = 0;
    end
`ifdef NOC_IFACE_LOOPBACK_EN
    lb_mode = 1;
`else
    lb_mode = 0;
`endif
    head          = (tx_q.size() > 0) ? tx_q[0] : '0;
    head_self     = (tx_q.size() > 0) && (head[DW-1 -: AW] == MY);
    exp_pe_ready  = ready_ok && (tx_q.size() < DEPTH);
    exp_noc_ready = ready_ok && (rx_q.size() < DEPTH);
    exp_noc_valid = (tx_q.size() > 0) && !(lb_mode && head_self);
    exp_noc_data  = exp_noc_valid ? head : '0;
    exp_pe_valid  = (rx_q.size() > 0);
    exp_pe_data   = exp_pe_valid ? rx_q[0] : '0;

    check("pe_ready",   64'(pe_ready_out),   64'(exp_pe_ready));
    check("noc_ready",  64'(noc_ready_out),  64'(exp_noc_ready));
    check("noc_valid",  64'(noc_valid_out),  64'(exp_noc_valid));
    check("noc_data",   64'(noc_data_out),   64'(exp_noc_data));
    check("pe_valid",   64'(pe_valid_out),   64'(exp_pe_valid));
    check("pe_data",    64'(pe_data_out),    64'(exp_pe_data));
    check("misroute",   64'(misroute),       64'(mis_pend));
    check("mis_count",  64'(misroute_count), 64'(mis_cnt));

    pe_acc      = pe_valid_in && exp_pe_ready;
    noc_in_acc  = noc_valid_in && exp_noc_ready;
    noc_in_me   = (noc_data_in[DW-1 -: AW] == MY);
    noc_out_acc = exp_noc_valid && noc_ready_in;
    lb          = lb_mode && head_self && !(noc_in_acc && noc_in_me) && (rx_q.size() < DEPTH);
    rx_pop      = exp_pe_valid && pe_ready_in;

    @(posedge clk);
    #1;
    if (rst) begin
      pe_acc     = 0;
      noc_in_acc = 0;
    end else begin
      if (noc_out_acc || lb) void'(tx_q.pop_front());
      if (rx_pop) void'(rx_q.pop_front());
      if (noc_in_acc && noc_in_me) rx_q.push_back(noc_data_in[PW-1:0]);
      if (lb) rx_q.push_back(head[PW-1:0]);
      if (pe_acc) tx_q.push_back({pe_dest_in, pe_data_in});
      mis_pend = noc_in_acc && !noc_in_me;
      if (mis_pend && mis_cnt < 255) mis_cnt++;
      ready_ok = 1;
    end
  endtask

  initial begin
    rst          = 1'b0;
    pe_data_in   = '0;
    pe_dest_in   = '0;
    pe_valid_in  = 1'b0;
    noc_ready_in = 1'b0;
    noc_data_in  = '0;
    noc_valid_in = 1'b0;
    pe_ready_in  = 1'b0;
    pe_acc       = 0;
    noc_in_acc   = 0;
    #1 rst = 1'b1;

    // Reset and release.
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Single PE write, dest=2, visible one cycle later and held one cycle.
    noc_ready_in = 1'b1;
    pe_valid_in  = 1'b1;
    pe_dest_in   = 2'd2;
    pe_data_in   = 32'h0000_00A5;
    step();
    pe_valid_in = 1'b0;
    check("a_valid", 64'(noc_valid_out), 64'd1);
    check("a_data",  64'(noc_data_out),  64'h2_0000_00A5);
    step();
    check("a_gone",  64'(noc_valid_out), 64'd0);
    step();

    // TX backpressure: 4 flits fill the FIFO, the 5th waits for the switch.
    noc_ready_in = 1'b0;
    pe_valid_in  = 1'b1;
    pe_dest_in   = 2'd1;
    pe_data_in   = 32'h100;
    sent         = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (pe_acc) begin
        sent++;
        pe_data_in = pe_data_in + 1;
        pe_dest_in = AW'($urandom_range(1, 3));
        if (sent == 5) pe_valid_in = 1'b0;
      end
      if (c == 7) begin
        check("b_sent4", 64'(sent), 64'd4);
        noc_ready_in = 1'b1;
      end
    end
    check("b_sent5", 64'(sent), 64'd5);

    // RX backpressure: payload 0x1234 held until the PE takes it.
    pe_ready_in  = 1'b0;
    noc_valid_in = 1'b1;
    noc_data_in  = {MY, 32'h1234};
    sent         = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (noc_in_acc) begin
        sent++;
        noc_data_in = {MY, 32'h1234 + 32'(sent)};
        if (sent == 5) noc_valid_in = 1'b0;
      end
      if (c == 7) begin
        check("c_sent4", 64'(sent), 64'd4);
        check("c_head",  64'(pe_data_out), 64'h1234);
        pe_ready_in = 1'b1;
      end
    end
    check("c_sent5", 64'(sent), 64'd5);

    // 260 misrouted flits: pulse every time, counter saturates at 255.
    mis_seen     = 0;
    noc_valid_in = 1'b1;
    for (int c = 0; c < 260; c++) begin
      noc_data_in = {2'd3, 32'($urandom)};
      step();
      if (misroute === 1'b1) mis_seen++;
    end
    noc_valid_in = 1'b0;
    check("d_pulses", 64'(mis_seen), 64'd260);
    check("d_count",  64'(misroute_count), 64'd255);
    step();

    // Random traffic with hold-while-stalled drivers.
    for (int c = 0; c < 400; c++) begin
      if (!(pe_valid_in && !pe_acc)) begin
        pe_valid_in = 1'($urandom_range(0, 1));
        pe_dest_in  = AW'($urandom_range(0, 3));
        pe_data_in  = $urandom;
      end
      if (!(noc_valid_in && !noc_in_acc)) begin
        noc_valid_in = 1'($urandom_range(0, 1));
        rnd_dest     = AW'($urandom_range(0, 3));
        noc_data_in  = {rnd_dest, 32'($urandom)};
      end
      noc_ready_in = ($urandom_range(0, 3) != 0);
      pe_ready_in  = ($urandom_range(0, 3) != 0);
      step();
    end
    pe_valid_in  = 1'b0;
    noc_valid_in = 1'b0;
    step();

    // Reset mid-burst with 3 flits queued each way.
    noc_ready_in = 1'b0;
    pe_ready_in  = 1'b0;
    pe_valid_in  = 1'b1;
    pe_dest_in   = 2'd3;
    noc_valid_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      pe_data_in  = 32'hA000 + 32'(c);
      noc_data_in = {MY, 32'hB000 + 32'(c)};
      step();
    end
    pe_valid_in  = 1'b0;
    noc_valid_in = 1'b0;
    check("f_txq3", 64'(tx_q.size()), 64'd3);
    rst = 1'b1;
    step();
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    check("f_pe_ready",  64'(pe_ready_out),  64'd1);
    check("f_noc_ready", 64'(noc_ready_out), 64'd1);

    // Self-addressed write.
    noc_ready_in = 1'b1;
    pe_ready_in  = 1'b0;
    pe_valid_in  = 1'b1;
    pe_dest_in   = MY;
    pe_data_in   = 32'h77;
    step();
    pe_valid_in = 1'b0;
    step();
`ifdef NOC_IFACE_LOOPBACK_EN
    check("g_lb_valid", 64'(pe_valid_out), 64'd1);
    check("g_lb_data",  64'(pe_data_out),  64'h77);
`else
    check("g_out_gone", 64'(noc_valid_out), 64'd0);
`endif
    pe_ready_in = 1'b1;
    repeat (2) step();

    // RX contention: 3 entries backlogged, self flit at TX head, NoC flit arrives.
    pe_ready_in  = 1'b0;
    noc_valid_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      noc_data_in = {MY, 32'hC000 + 32'(c)};
      step();
    end
    noc_valid_in = 1'b0;
    pe_valid_in  = 1'b1;
    pe_data_in   = 32'hAA;
    step();
    pe_valid_in  = 1'b0;
    noc_valid_in = 1'b1;
    noc_data_in  = {MY, 32'hBB};
    step();
    noc_valid_in = 1'b0;
    repeat (2) step();
    pe_ready_in = 1'b1;
    repeat (8) step();
    check("h_rx_empty", 64'(pe_valid_out), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
